// File: rtl/exception_ctrl.sv
// CP0 exception controller: selects the highest-priority MEM-stage exception,
// redirects fetch, and maintains Status/Cause/EPC/BadVAddr/Count/Compare.
module exception_ctrl #(
  parameter logic [31:0] EXC_ENTRY = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delayslot,
  input  logic        eret_flag,
  input  logic        syscall_flag,
  input  logic        break_flag,
  input  logic        ri_flag,
  input  logic        ov_flag,
  input  logic        if_adel,
  input  logic        mem_adel,
  input  logic        mem_ades,
  input  logic [31:0] mem_addr,
  input  logic [5:0]  hw_int,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  output logic        flush,
  output logic [31:0] exc_pc
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [4:0] CODE_INT  = 5'h00;
  localparam logic [4:0] CODE_ADEL = 5'h04;
  localparam logic [4:0] CODE_ADES = 5'h05;
  localparam logic [4:0] CODE_SYS  = 5'h08;
  localparam logic [4:0] CODE_BP   = 5'h09;
  localparam logic [4:0] CODE_RI   = 5'h0a;
  localparam logic [4:0] CODE_OV   = 5'h0c;

  logic [31:0] badvaddr, count, compare, epc;
  logic [7:0]  status_im;
  logic        status_exl, status_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip_hw;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_exccode;
  logic        toggle, timer_int;

  logic [7:0]  cause_ip;
  logic        int_req, exc_take, eret_take, fetch_err, data_err, wr;
  logic [4:0]  exc_code;
  logic [31:0] status_word, cause_word;

  assign cause_ip    = {cause_ip_hw, cause_ip_sw};
  assign status_word = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
  assign cause_word  = {cause_bd, 15'd0, cause_ip, 1'b0, cause_exccode, 2'b00};
  assign int_req     = status_ie & ~status_exl & (|(cause_ip & status_im));

  always_comb begin
    exc_take  = 1'b0;
    exc_code  = CODE_INT;
    fetch_err = 1'b0;
    data_err  = 1'b0;
    if (mem_valid) begin
      if (int_req) begin
        exc_take = 1'b1;
        exc_code = CODE_INT;
      end else if (if_adel) begin
        exc_take  = 1'b1;
        exc_code  = CODE_ADEL;
        fetch_err = 1'b1;
      end else if (ri_flag) begin
        exc_take = 1'b1;
        exc_code = CODE_RI;
      end else if (ov_flag) begin
        exc_take = 1'b1;
        exc_code = CODE_OV;
      end else if (syscall_flag) begin
        exc_take = 1'b1;
        exc_code = CODE_SYS;
      end else if (break_flag) begin
        exc_take = 1'b1;
        exc_code = CODE_BP;
      end else if (mem_adel) begin
        exc_take = 1'b1;
        exc_code = CODE_ADEL;
        data_err = 1'b1;
      end else if (mem_ades) begin
        exc_take = 1'b1;
        exc_code = CODE_ADES;
        data_err = 1'b1;
      end
    end
  end

  assign eret_take = mem_valid & eret_flag & ~exc_take;
  assign flush     = rst & (exc_take | eret_take);
  assign exc_pc    = !flush ? 32'd0 : (exc_take ? EXC_ENTRY : epc);
  // A redirect squashes the MTC0 travelling with the faulting instruction.
  assign wr        = cp0_we & ~flush;

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_raddr)
      REG_BADVADDR: cp0_rdata = badvaddr;
      REG_COUNT:    cp0_rdata = count;
      REG_COMPARE:  cp0_rdata = compare;
      REG_STATUS:   cp0_rdata = status_word;
      REG_CAUSE:    cp0_rdata = cause_word;
      REG_EPC:      cp0_rdata = epc;
      default:      cp0_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      badvaddr      <= 32'd0;
      count         <= 32'd0;
      compare       <= 32'd0;
      epc           <= 32'd0;
      status_im     <= 8'd0;
      status_exl    <= 1'b0;
      status_ie     <= 1'b0;
      cause_bd      <= 1'b0;
      cause_ip_hw   <= 6'd0;
      cause_ip_sw   <= 2'd0;
      cause_exccode <= 5'd0;
      toggle        <= 1'b0;
      timer_int     <= 1'b0;
    end else begin
      cause_ip_hw <= {hw_int[5] | timer_int, hw_int[4:0]};

      if (wr && cp0_waddr == REG_COUNT) begin
        count  <= cp0_wdata;
        toggle <= 1'b0;
      end else begin
        toggle <= ~toggle;
        if (toggle) count <= count + 32'd1;
      end

      if (wr && cp0_waddr == REG_COMPARE) begin
        compare   <= cp0_wdata;
        timer_int <= 1'b0;
      end else if (count == compare) begin
        timer_int <= 1'b1;
      end

      if (wr && cp0_waddr == REG_STATUS) begin
        status_im  <= cp0_wdata[15:8];
        status_exl <= cp0_wdata[1];
        status_ie  <= cp0_wdata[0];
      end
      if (wr && cp0_waddr == REG_CAUSE) cause_ip_sw <= cp0_wdata[9:8];
      if (wr && cp0_waddr == REG_EPC)   epc <= cp0_wdata;

      if (exc_take) begin
        cause_exccode <= exc_code;
        status_exl    <= 1'b1;
        // Nested exceptions keep the original return point.
        if (!status_exl) begin
          epc      <= mem_in_delayslot ? (mem_pc - 32'd4) : mem_pc;
          cause_bd <= mem_in_delayslot;
        end
        if (fetch_err)     badvaddr <= mem_pc;
        else if (data_err) badvaddr <= mem_addr;
      end else if (eret_take) begin
        status_exl <= 1'b0;
      end
    end
  end

endmodule
